alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 SHALL have ports num1 and num2, input, WIDTH, the operands.
REQ-005 SHALL have port op, input, 4, the operation code (REQ-013).
REQ-006 SHALL have port in_valid, input, 1, and port in_ready, output, 1, the request handshake.
REQ-007 SHALL have port result, output, WIDTH, the registered result.
REQ-008 SHALL have port out_valid, output, 1, and port out_ready, input, 1, the response handshake.
REQ-009 SHALL have output flags, each 1 bit and registered with result: zero (result==0), ovf (signed overflow, ADD/SUB only, else 0), div_zero (DIVU by 0, else 0).

Function
REQ-010 SHALL accept a request on a cycle with in_valid && in_ready; operands and op are captured at that edge.
REQ-011 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), allowing accept on the same cycle an old result drains.
REQ-012 SHALL hold result, flags and out_valid stable while out_valid && !out_ready; out_valid clears on a handshake with no new completion on that edge.
REQ-013 SHALL decode op as: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 num1&~num2, 0101 num1|~num2, 0110 SUB, 0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLT signed, 1100 MULTU, 1101 DIVU, 1110 MFHI, 1111 MFLO.
REQ-014 SHALL, for SLT and SLTU, return 1 or 0 zero-extended to WIDTH; shifts use num2[log2(WIDTH)-1:0] as the amount, shifting num1.
REQ-015 SHALL complete all ops except MULTU/DIVU with latency 1: out_valid high on the edge after acceptance.
REQ-016 SHALL use FSM states IDLE, MUL and DIV; IDLE->MUL on accepted MULTU, IDLE->DIV on accepted DIVU, MUL/DIV->IDLE on the final iteration; there are no other transitions except reset.
REQ-017 SHALL compute MULTU by a shift-add iteration, one bit per cycle for WIDTH cycles; the final iteration edge writes the 2*WIDTH product {HI,LO}, sets result=LO and out_valid, giving latency WIDTH+1.
REQ-018 SHALL compute DIVU by restoring unsigned division, one bit per cycle for WIDTH cycles; completion writes LO=quotient, HI=remainder, result=quotient, giving latency WIDTH+1.
REQ-019 SHALL, for DIVU with num2==0, still take WIDTH+1 cycles and produce quotient all-ones, remainder=num1 and div_zero=1.
REQ-020 SHALL modify HI/LO only at MULTU/DIVU completion; MFHI/MFLO return the HI/LO values present at acceptance.
REQ-021 SHALL use a log2(WIDTH)+1 bit iteration counter, loaded at acceptance and decremented each MUL/DIV cycle, with no wrap.
REQ-022 SHALL perform ADD/SUB/SLTU arithmetic mod 2^WIDTH; ovf = sign-operand mismatch rule for two's complement.

Reset
REQ-023 SHALL, while rst is high at an edge, set state=IDLE, counter=0, HI=LO=0, result=0, zero=0, ovf=0, div_zero=0 and out_valid=0.
REQ-024 SHALL, on reset mid-MUL/DIV, abort the operation, produce no out_valid, and leave HI/LO at 0; in_ready is high on the first cycle after rst deasserts.
REQ-025 SHALL keep in_ready low during reset cycles.

Configuration
REQ-026 SHALL, with macro ALU_MDU_DIV_EN defined, implement DIV state and divider per REQ-018/019.
REQ-027 SHALL, without ALU_MDU_DIV_EN, contain no divider logic or DIV state; DIVU completes in 1 cycle with result=0, zero=1, div_zero=0, HI/LO unchanged.

Verification (WIDTH=32, ALU_MDU_DIV_EN defined unless noted)
REQ-028 SHALL cover ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, ovf=1, zero=0, out_valid exactly 1 cycle after accept.
REQ-029 SHALL cover SLTU 0x00000001,0xFFFFFFFF -> result 1; SLT same operands -> result 0; SRA 0x80000000 by 4 -> result 0xF8000000.
REQ-030 SHALL cover MULTU 0xFFFFFFFF*0x00000002 -> result 0xFFFFFFFE after 33 cycles, in_ready low throughout; then MFHI -> 0x00000001.
REQ-031 SHALL cover DIVU 100/7 -> result 14, MFHI -> 2; DIVU 5/0 -> result 0xFFFFFFFF, div_zero=1, MFHI -> 5; and, without the macro, DIVU 100/7 -> result 0 in 1 cycle.
REQ-032 SHALL cover holding out_ready low 3 cycles after an AND result -> result/flags stable, in_ready low; then a new request is accepted on the same cycle out_ready rises.
REQ-033 SHALL cover rst asserted on cycle 10 of a MULTU -> no out_valid, HI=LO=0, in_ready=1 on the cycle after rst falls.

Source files
------------

// File: rtl/alu_mdu.sv
// ============================================================================
//  Module   : alu_mdu
//  Purpose  : Single-cycle ALU with iterative multiply (MULTU) and optional
//             restoring divider (DIVU); HI/LO registers read by MFHI/MFLO.
//             Define ALU_MDU_DIV_EN to build the divider and its DIV state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             ovf,
  output logic             div_zero
);

  localparam int LOGW = $clog2(WIDTH);

  localparam logic [LOGW:0] c_iter = (LOGW+1)'(WIDTH);
  localparam logic [LOGW:0] c_last = (LOGW+1)'(1);

  localparam logic [3:0] c_op_and   = 4'b0000;
  localparam logic [3:0] c_op_or    = 4'b0001;
  localparam logic [3:0] c_op_add   = 4'b0010;
  localparam logic [3:0] c_op_xor   = 4'b0011;
  localparam logic [3:0] c_op_andn  = 4'b0100;
  localparam logic [3:0] c_op_orn   = 4'b0101;
  localparam logic [3:0] c_op_sub   = 4'b0110;
  localparam logic [3:0] c_op_sltu  = 4'b0111;
  localparam logic [3:0] c_op_sll   = 4'b1000;
  localparam logic [3:0] c_op_srl   = 4'b1001;
  localparam logic [3:0] c_op_sra   = 4'b1010;
  localparam logic [3:0] c_op_slt   = 4'b1011;
  localparam logic [3:0] c_op_multu = 4'b1100;
`ifdef ALU_MDU_DIV_EN
  localparam logic [3:0] c_op_divu  = 4'b1101;
`endif
  localparam logic [3:0] c_op_mfhi  = 4'b1110;
  localparam logic [3:0] c_op_mflo  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
`ifdef ALU_MDU_DIV_EN
    , DIV = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic [LOGW:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_div_zero;
  logic             r_out_valid;
  // Shared iteration registers: partial-high/remainder, multiplier/quotient, multiplicand/divisor.
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_m;

  logic             w_in_ready;
  logic [LOGW-1:0]  w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_ovf;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_x;
  logic [WIDTH-1:0] w_mul_y;

  assign w_in_ready = !rst && (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_shamt    = num2[LOGW-1:0];
  assign w_sum      = num1 + num2;
  assign w_diff     = num1 - num2;

  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (op)
      c_op_and:  w_alu = num1 & num2;
      c_op_or:   w_alu = num1 | num2;
      c_op_add: begin
        w_alu     = w_sum;
        w_alu_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (w_sum[WIDTH-1] != num1[WIDTH-1]);
      end
      c_op_xor:  w_alu = num1 ^ num2;
      c_op_andn: w_alu = num1 & ~num2;
      c_op_orn:  w_alu = num1 | ~num2;
      c_op_sub: begin
        w_alu     = w_diff;
        w_alu_ovf = (num1[WIDTH-1] != num2[WIDTH-1]) && (w_diff[WIDTH-1] != num1[WIDTH-1]);
      end
      c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (num1 < num2)};
      c_op_sll:  w_alu = num1 << w_shamt;
      c_op_srl:  w_alu = num1 >> w_shamt;
      c_op_sra:  w_alu = $unsigned($signed(num1) >>> w_shamt);
      c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
      c_op_mfhi: w_alu = r_hi;
      c_op_mflo: w_alu = r_lo;
      default:   w_alu = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the high half when the multiplier LSB is set, then shift right.
  assign w_mul_sum = {1'b0, r_x} + (r_y[0] ? {1'b0, r_m} : '0);
  assign w_mul_x   = w_mul_sum[WIDTH:1];
  assign w_mul_y   = {w_mul_sum[0], r_y[WIDTH-1:1]};

`ifdef ALU_MDU_DIV_EN
  logic             r_dz_pend;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_div_sub;
  logic [WIDTH-1:0] w_div_x;
  logic [WIDTH-1:0] w_div_y;

  // Restoring step; a zero divisor always "fits", yielding all-ones quotient and remainder=dividend.
  assign w_div_sh  = {r_x, r_y[WIDTH-1]};
  assign w_div_ok  = (w_div_sh >= {1'b0, r_m});
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_m;
  assign w_div_x   = w_div_ok ? w_div_sub : w_div_sh[WIDTH-1:0];
  assign w_div_y   = {r_y[WIDTH-2:0], w_div_ok};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_m         <= '0;
`ifdef ALU_MDU_DIV_EN
      r_dz_pend   <= 1'b0;
`endif
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && w_in_ready) begin
            if (op == c_op_multu) begin
              r_x     <= '0;
              r_y     <= num2;
              r_m     <= num1;
              r_cnt   <= c_iter;
              r_state <= MUL;
            end
`ifdef ALU_MDU_DIV_EN
            else if (op == c_op_divu) begin
              r_x       <= '0;
              r_y       <= num1;
              r_m       <= num2;
              r_dz_pend <= (num2 == '0);
              r_cnt     <= c_iter;
              r_state   <= DIV;
            end
`endif
            else begin
              r_result    <= w_alu;
              r_zero      <= (w_alu == '0);
              r_ovf       <= w_alu_ovf;
              r_div_zero  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          r_x <= w_mul_x;
          r_y <= w_mul_y;
          if (r_cnt != '0) r_cnt <= r_cnt - c_last;
          if (r_cnt == c_last) begin
            r_hi        <= w_mul_x;
            r_lo        <= w_mul_y;
            r_result    <= w_mul_y;
            r_zero      <= (w_mul_y == '0);
            r_ovf       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
`ifdef ALU_MDU_DIV_EN
        DIV: begin
          r_x <= w_div_x;
          r_y <= w_div_y;
          if (r_cnt != '0) r_cnt <= r_cnt - c_last;
          if (r_cnt == c_last) begin
            r_hi        <= w_div_x;
            r_lo        <= w_div_y;
            r_result    <= w_div_y;
            r_zero      <= (w_div_y == '0);
            r_ovf       <= 1'b0;
            r_div_zero  <= r_dz_pend;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign div_zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
//  Module   : tb_alu_mdu
//  Purpose  : Directed self-checking bench for alu_mdu (WIDTH=32); divider
//             expectations follow ALU_MDU_DIV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic [3:0]  op = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        zero;
  logic        ovf;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_valid(out_valid), .out_ready(out_ready),
    .zero(zero), .ovf(ovf), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        v;
  } vec_t;

  localparam vec_t vecs [12] = '{
    '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
    '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0},
    '{4'hB, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
    '{4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0},
    '{4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
    '{4'h3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b0},
    '{4'h8, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0},
    '{4'h9, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0},
    '{4'h4, 32'hF0F0F0F0, 32'hFF000000, 32'h00F0F0F0, 1'b0},
    '{4'h5, 32'h00000000, 32'hFFFFFFFE, 32'h00000001, 1'b0},
    '{4'h1, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0},
    '{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0}
  };

  // Present one request and hold it until the accepting edge has passed.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    op = o; num1 = a; num2 = b; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: in_ready=%b required 1 (op %h)", in_ready, o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if ({result, zero, ovf, div_zero} !== 35'd0)
      begin errors++; $display("FAIL reset_outputs: result=%h z=%b o=%b dz=%b required all 0", result, zero, ovf, div_zero); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_alu;
    int lat;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL alu_latency[%0d]: got %0d required 1", i, lat); end
      checks++;
      if (result !== vecs[i].r) begin errors++; $display("FAIL alu_result[%0d]: got %h required %h", i, result, vecs[i].r); end
      checks++;
      if (ovf !== vecs[i].v) begin errors++; $display("FAIL alu_ovf[%0d]: got %b required %b", i, ovf, vecs[i].v); end
      checks++;
      if (zero !== (vecs[i].r == 32'd0)) begin errors++; $display("FAIL alu_zero[%0d]: got %b required %b", i, zero, vecs[i].r == 32'd0); end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_valid_drop: got %b required 0", out_valid); end
      end
    end
  endtask

  task automatic test_mul;
    int lat;
    send(4'hC, 32'hFFFFFFFF, 32'h00000002);
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready: cycle %0d got %b required 0", lat, in_ready); end
      end
    end while (!out_valid && lat < 100);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", lat); end
    checks++;
    if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_result: got %h required fffffffe", result); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'h00000001) begin errors++; $display("FAIL mul_mfhi: got %h required 00000001", result); end
    send(4'hF, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_mflo: got %h required fffffffe", result); end
    send(4'hC, 32'h12345678, 32'h00000010);
    wait_out(lat);
    checks++;
    if (result !== 32'h23456780) begin errors++; $display("FAIL mul2_result: got %h required 23456780", result); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'h00000001) begin errors++; $display("FAIL mul2_mfhi: got %h required 00000001", result); end
  endtask

  task automatic test_div;
    int lat;
`ifdef ALU_MDU_DIV_EN
    send(4'hD, 32'd100, 32'd7);
    wait_out(lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d required 33", lat); end
    checks++;
    if (result !== 32'd14 || div_zero !== 1'b0)
      begin errors++; $display("FAIL div_result: got %h dz=%b required 0000000e dz=0", result, div_zero); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'd2) begin errors++; $display("FAIL div_mfhi: got %h required 00000002", result); end
    send(4'hD, 32'd5, 32'd0);
    wait_out(lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div0_latency: got %0d required 33", lat); end
    checks++;
    if (result !== 32'hFFFFFFFF || div_zero !== 1'b1 || zero !== 1'b0)
      begin errors++; $display("FAIL div0_result: got %h dz=%b z=%b required ffffffff dz=1 z=0", result, div_zero, zero); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'd5 || div_zero !== 1'b0)
      begin errors++; $display("FAIL div0_mfhi: got %h dz=%b required 00000005 dz=0", result, div_zero); end
`else
    send(4'hD, 32'd100, 32'd7);
    wait_out(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL nodiv_latency: got %0d required 1", lat); end
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || div_zero !== 1'b0)
      begin errors++; $display("FAIL nodiv_result: got %h z=%b dz=%b required 0 z=1 dz=0", result, zero, div_zero); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'h00000001) begin errors++; $display("FAIL nodiv_mfhi: got %h required 00000001", result); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    send(4'h0, 32'hFF00FF00, 32'h0FF00FF0);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 32'h0F000F00)
      begin errors++; $display("FAIL bp_first: lat=%0d result=%h required 1 0f000f00", lat, result); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h0F000F00 || zero !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: v=%b r=%h z=%b o=%b rdy=%b required 1 0f000f00 0 0 0",
                                 k, out_valid, result, zero, ovf, in_ready); end
    end
    op = 4'h1; num1 = 32'h00000F00; num2 = 32'h000000F0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_same_cycle_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h00000FF0)
      begin errors++; $display("FAIL bp_second: v=%b r=%h required 1 00000ff0", out_valid, result); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul;
    int lat;
    logic seen;
    send(4'hC, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rmid_during: rdy=%b v=%b required 0 0", in_ready, out_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b required 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_valid: out_valid seen=%b required 0", seen); end
    send(4'hE, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rmid_hi: got %h required 00000000", result); end
    send(4'hF, 32'h0, 32'h0);
    wait_out(lat);
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rmid_lo: got %h required 00000000", result); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
